saw_gen_nco: RTL and testbench

Parametrised, clocked successor to the counter-driven sawtooth generator in the AWG datapath. It uses a phase accumulator (NCO) with a frequency tuning word, phase offset and amplitude scaling, and supports four waveform modes: sawtooth, reverse sawtooth, triangle and square. It sits between the front-panel state registers (freq/amp/phase) and the DAC interface. It drives one DAC sample per clock through a fixed 2-stage pipeline and emits a cycle-aligned wrap marker for scope triggering.

---
 rtl/saw_gen_nco.sv | 168 ++++++++++++++++
 tb/tb_saw_gen_nco.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/saw_gen_nco.sv
// saw_gen_nco: phase-accumulator waveform generator feeding the DAC.
// Waveforms: saw, reverse saw, triangle and square, each with a phase offset
// and an amplitude scale. One sample leaves per clock through a 2-stage
// pipeline, together with a wrap marker aligned to that sample.
// Optional build macro SAW_GEN_SHADOW_EN: the tuning inputs are copied into
// shadow registers, and those copies change only at a period boundary, so
// retuning does not glitch.
module saw_gen_nco #(
   parameter int DAC_W  = 14,
   parameter int ACC_W  = 24,
   parameter int FREQ_W = 12,
   parameter int AMP_W  = 8,
   parameter int PH_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              sync,
   input  logic [1:0]        mode,
   input  logic [FREQ_W-1:0] state_freq,
   input  logic [AMP_W-1:0]  state_amp,
   input  logic [PH_W-1:0]   state_phase,
   output logic [DAC_W-1:0]  DAC_in,
   output logic              wrap
);

   localparam int PROD_W = DAC_W + AMP_W + 1;

   // Parameter values actually used by the datapath
   logic [FREQ_W-1:0] freq_eff_s;
   logic [AMP_W-1:0]  amp_eff_s;
   logic [PH_W-1:0]   ph_eff_s;
   logic [1:0]        mode_eff_s;

   // Stage 0: accumulator
   logic [ACC_W:0]    sum_s;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              flag0_q, flag0_d;
   logic              en0_q;
   logic              carry_s;

   // Stage 1: shaped sample
   logic [DAC_W-1:0]  p_s, tri_s, ph_ext_s, shape_s, s1_d, s1_q;
   logic              flag1_q;
   logic [AMP_W-1:0]  amp1_q;

   // Stage 2: scaled sample
   logic [AMP_W:0]    amp_p1_s;
   logic [PROD_W-1:0] prod_s;
   logic [DAC_W-1:0]  y_s;

`ifdef SAW_GEN_SHADOW_EN
   logic [FREQ_W-1:0] freq_sh_q;
   logic [AMP_W-1:0]  amp_sh_q;
   logic [PH_W-1:0]   ph_sh_q;
   logic [1:0]        mode_sh_q;

   // Shadows reload only while idle, on a restart, or at the wrap edge
   always_ff @(posedge clk) begin
      if (rst || !en || sync || carry_s) begin
         freq_sh_q <= state_freq;
         amp_sh_q  <= state_amp;
         ph_sh_q   <= state_phase;
         mode_sh_q <= mode;
      end else begin
         freq_sh_q <= freq_sh_q;
         amp_sh_q  <= amp_sh_q;
         ph_sh_q   <= ph_sh_q;
         mode_sh_q <= mode_sh_q;
      end
   end

   assign freq_eff_s = freq_sh_q;
   assign amp_eff_s  = amp_sh_q;
   assign ph_eff_s   = ph_sh_q;
   assign mode_eff_s = mode_sh_q;
`else
   assign freq_eff_s = state_freq;
   assign amp_eff_s  = state_amp;
   assign ph_eff_s   = state_phase;
   assign mode_eff_s = mode;
`endif

   // Carry-out of the wide add is the wrap event
   assign sum_s = {1'b0, acc_q} + (ACC_W+1)'(freq_eff_s);

   // Accumulator next state: sync beats en; idle holds phase at zero
   always_comb begin
      acc_d   = {ACC_W{1'b0}};
      flag0_d = 1'b0;
      carry_s = 1'b0;
      if (sync) begin
         acc_d   = {ACC_W{1'b0}};
         flag0_d = 1'b1;
      end else if (!en) begin
         acc_d   = {ACC_W{1'b0}};
         flag0_d = 1'b0;
      end else begin
         acc_d   = sum_s[ACC_W-1:0];
         flag0_d = sum_s[ACC_W];
         carry_s = sum_s[ACC_W];
      end
   end

   // Stage 0 registers; en is carried along so the output zeroes in step
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= {ACC_W{1'b0}};
         flag0_q <= 1'b0;
         en0_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         flag0_q <= flag0_d;
         en0_q   <= en;
      end
   end

   assign ph_ext_s = DAC_W'(ph_eff_s) << (DAC_W - PH_W);
   assign p_s      = acc_q[ACC_W-1 -: DAC_W] + ph_ext_s;
   assign tri_s    = {p_s[DAC_W-2:0], 1'b0};

   // Waveform shaping from the offset phase
   always_comb begin
      shape_s = {DAC_W{1'b0}};
      case (mode_eff_s)
         2'b00:   shape_s = p_s;
         2'b01:   shape_s = ~p_s;
         2'b10:   shape_s = p_s[DAC_W-1] ? ~tri_s : tri_s;
         2'b11:   shape_s = p_s[DAC_W-1] ? {DAC_W{1'b1}} : {DAC_W{1'b0}};
         default: shape_s = {DAC_W{1'b0}};
      endcase
      if (en0_q) begin
         s1_d = shape_s;
      end else begin
         s1_d = {DAC_W{1'b0}};
      end
   end

   // Stage 1 registers: shaped sample, wrap flag and the amplitude to apply
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= {DAC_W{1'b0}};
         flag1_q <= 1'b0;
         amp1_q  <= {AMP_W{1'b0}};
      end else begin
         s1_q    <= s1_d;
         flag1_q <= flag0_q;
         amp1_q  <= amp_eff_s;
      end
   end

   // Full-width product; amp = max gives unity gain
   assign amp_p1_s = {1'b0, amp1_q} + {{AMP_W{1'b0}}, 1'b1};
   assign prod_s   = PROD_W'(s1_q) * PROD_W'(amp_p1_s);
   assign y_s      = DAC_W'(prod_s >> AMP_W);

   // Stage 2 registers drive the DAC and the trigger marker
   always_ff @(posedge clk) begin
      if (rst) begin
         DAC_in <= {DAC_W{1'b0}};
         wrap   <= 1'b0;
      end else begin
         DAC_in <= y_s;
         wrap   <= flag1_q;
      end
   end

endmodule

// File: tb/tb_saw_gen_nco.sv
// Self-checking bench for saw_gen_nco: directed scenarios plus random traffic,
// all compared against an arithmetic reference model of the sample stream.
module tb_saw_gen_nco;

   localparam int DAC_W  = 14;
   localparam int ACC_W  = 24;
   localparam int FREQ_W = 12;
   localparam int AMP_W  = 8;
   localparam int PH_W   = 8;
   localparam int FULL   = 1 << DAC_W;
   localparam int HALF   = FULL / 2;
   localparam int NMAX   = FULL - 1;
   localparam longint ACC_MOD = longint'(1) << ACC_W;

   logic              clk = 1'b0;
   logic              rst, en, sync;
   logic [1:0]        mode;
   logic [FREQ_W-1:0] freq;
   logic [AMP_W-1:0]  amp;
   logic [PH_W-1:0]   ph;
   logic [DAC_W-1:0]  dac;
   logic              wrap;

   int total = 0;
   int bad   = 0;

   // reference model state
   longint m_acc;
   bit     m_ren, m_rflag, m_pendw, e_wrap;
   int     m_pend, e_dac;
   int     sh_freq, sh_amp, sh_ph, sh_mode;

   always #5 clk = ~clk;

   saw_gen_nco #(.DAC_W(DAC_W), .ACC_W(ACC_W), .FREQ_W(FREQ_W),
                 .AMP_W(AMP_W), .PH_W(PH_W)) dut (
      .clk(clk), .rst(rst), .en(en), .sync(sync), .mode(mode),
      .state_freq(freq), .state_amp(amp), .state_phase(ph),
      .DAC_in(dac), .wrap(wrap));

   function automatic int ref_sample(longint a, int md, int am, int phv);
      int p, s;
      p = (int'(a >> (ACC_W - DAC_W)) + (phv << (DAC_W - PH_W))) % FULL;
      case (md)
         0: s = p;
         1: s = NMAX - p;
         2: s = (p < HALF) ? 2 * p : NMAX - 2 * (p - HALF);
         3: s = (p >= HALF) ? NMAX : 0;
         default: s = 0;
      endcase
      return (s * (am + 1)) >> AMP_W;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // advance the model by one clock edge using the inputs present at the edge
   task automatic model_edge();
      int uf, ua, up, um;
      longint sum;
      bit carry;
      carry = 1'b0;
`ifdef SAW_GEN_SHADOW_EN
      uf = sh_freq; ua = sh_amp; up = sh_ph; um = sh_mode;
`else
      uf = int'(freq); ua = int'(amp); up = int'(ph); um = int'(mode);
`endif
      if (rst) begin
         m_acc = 0; m_ren = 0; m_rflag = 0;
         m_pend = 0; m_pendw = 0; e_dac = 0; e_wrap = 0;
      end else begin
         e_dac   = m_pend;
         e_wrap  = m_pendw;
         m_pend  = m_ren ? ref_sample(m_acc, um, ua, up) : 0;
         m_pendw = m_rflag;
         if (sync) begin
            m_acc = 0; m_rflag = 1;
         end else if (!en) begin
            m_acc = 0; m_rflag = 0;
         end else begin
            sum     = m_acc + uf;
            carry   = (sum >= ACC_MOD);
            m_acc   = sum % ACC_MOD;
            m_rflag = carry;
         end
         m_ren = en;
      end
      if (rst || !en || sync || carry) begin
         sh_freq = int'(freq); sh_amp = int'(amp);
         sh_ph = int'(ph); sh_mode = int'(mode);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("model_dac", {18'd0, dac}, e_dac);
      chk("model_wrap", {31'd0, wrap}, {31'd0, e_wrap});
   endtask

   task automatic restart(input logic [1:0] md, input int f, input int a, input int p);
      rst = 1'b1; en = 1'b0; sync = 1'b0;
      mode = md; freq = FREQ_W'(f); amp = AMP_W'(a); ph = PH_W'(p);
      step();
      rst = 1'b0;
      step();
      en = 1'b1;
      step();
      step();
   endtask

   initial begin
      int t1, t2, prev, v, exp_step;
      rst = 1'b1; en = 1'b0; sync = 1'b0; mode = 2'b00;
      freq = 12'd1024; amp = 8'd255; ph = 8'd0;

      // reset state
      repeat (3) step();
      chk("rst_dac", {18'd0, dac}, 32'd0);
      chk("rst_wrap", {31'd0, wrap}, 32'd0);

      // sawtooth ramp: 0,1,2,... then wrap on the second zero
      restart(2'b00, 1024, 255, 0);
      chk("ramp_first", {18'd0, dac}, 32'd0);
      for (int i = 1; i <= 16384; i++) begin
         step();
         chk("ramp_val", {18'd0, dac}, i % 16384);
         if (i == 16384) chk("ramp_wrap", {31'd0, wrap}, 32'd1);
      end
      repeat (4) step();

      // square with half amplitude: 0 / 8191 in runs of 8192
      restart(2'b11, 1024, 127, 0);
      t1 = -1; t2 = -1;
      for (int i = 1; i <= 16400; i++) begin
         step();
         chk("sq_level", ((dac == 14'd0) || (dac == 14'd8191)) ? 32'd1 : 32'd0, 32'd1);
         if (t1 < 0 && dac == 14'd8191) t1 = i;
         if (t1 >= 0 && t2 < 0 && dac == 14'd0) t2 = i;
      end
      chk("sq_run", t2 - t1, 32'd8192);

      // triangle: rises by 2 to 16382, then falls by 2 to 1
      restart(2'b10, 1024, 255, 0);
      for (int i = 1; i <= 16384; i++) begin
         step();
         if (i == 1)     chk("tri_start", {18'd0, dac}, 32'd2);
         if (i == 8191)  chk("tri_peak", {18'd0, dac}, 32'd16382);
         if (i == 8193)  chk("tri_fall", {18'd0, dac}, 32'd16381);
         if (i == 16383) chk("tri_end", {18'd0, dac}, 32'd1);
      end

      // phase offset with a sync pulse during a saw run
      restart(2'b00, 1024, 255, 64);
      repeat (100) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      step();
      step();
      chk("sync_dac", {18'd0, dac}, 32'd4096);
      chk("sync_wrap", {31'd0, wrap}, 32'd1);
      step();
      chk("sync_next", {18'd0, dac}, 32'd4097);
      step();
      chk("sync_next2", {18'd0, dac}, 32'd4098);
      sync = 1'b1;
      repeat (4) step();
      sync = 1'b0;
      repeat (6) step();

      // reset mid-run clears the outputs on that edge
      rst = 1'b1;
      step();
      chk("midrst_dac", {18'd0, dac}, 32'd0);
      chk("midrst_wrap", {31'd0, wrap}, 32'd0);
      rst = 1'b0; en = 1'b1;
      repeat (50) step();

      // enable dropped: zero from two edges after the first idle edge
      en = 1'b0;
      step();
      step();
      step();
      chk("endrop_dac", {18'd0, dac}, 32'd0);
      repeat (3) step();

      // freq = 0: DC output, never a wrap
      en = 1'b1; freq = 12'd0;
      repeat (4) step();
      v = e_dac;
      for (int i = 0; i < 40; i++) begin
         step();
         chk("dc_hold", {18'd0, dac}, v);
         chk("dc_nowrap", {31'd0, wrap}, 32'd0);
      end

      // retune mid-period
      restart(2'b00, 1024, 255, 0);
      repeat (50) step();
      freq = 12'd2048;
      repeat (3) step();
      prev = int'(dac);
      step();
`ifdef SAW_GEN_SHADOW_EN
      exp_step = 1;
`else
      exp_step = 2;
`endif
      chk("retune_step", int'(dac) - prev, exp_step);
      repeat (16400) step();

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst  = ($urandom_range(0, 199) == 0);
         en   = ($urandom_range(0, 9) != 0);
         sync = ($urandom_range(0, 49) == 0);
         if ((i % 64) == 0) begin
            mode = 2'($urandom_range(0, 3));
            freq = FREQ_W'($urandom);
            amp  = AMP_W'($urandom);
            ph   = PH_W'($urandom);
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
